alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 12 +
 rtl/op_fifo.sv | 40 ++++
 rtl/alu_issue.sv | 86 ++++++++
 tb/tb_alu_issue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM states and helpers shared by alu_issue.
package alu_pkg;
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_INC = 3'b001;
  localparam logic [2:0] F_SUB = 3'b010;
  localparam logic [2:0] F_DEC = 3'b011;
  localparam logic [2:0] F_MUL = 3'b100;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;
  function automatic logic is_illegal(input logic [2:0] f);
    return f[2:1] == 2'b11;
  endfunction
endpackage

// File: rtl/op_fifo.sv
// op_fifo: power-of-two operation queue with occupancy count.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int EW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [EW-1:0]            wdata,
  output logic [EW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
endmodule

// File: rtl/alu_issue.sv
// alu_issue: queues ALU ops, issues one per two cycles, holds the result until taken.
// Optional ALU_ISSUE_ACC_EN: acc entries take operand A from the previous result.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [2:0]             in_f,
  input  logic                   in_acc,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [2:0]             alu_f,
  input  logic [W-1:0]           alu_r,
  output logic [W-1:0]           res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * W + 4;
  state_e state_q, state_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic err_q, err_d;
  logic illegal, push, pop, full, issuing;
  logic [EW-1:0] head;
  logic [W-1:0] head_a, head_b, a_sel;
  logic [2:0] head_f;
  logic head_acc;
  logic [CW-1:0] count_after;
  op_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata({in_a, in_b, in_f, in_acc}),
    .rdata(head),
    .count(count),
    .full(full)
  );
  assign {head_a, head_b, head_f, head_acc} = head;
  always_comb begin
    illegal = is_illegal(in_f);
    in_ready = illegal || !full;
    push = in_valid && in_ready && !illegal;
    pop = state_q == ISSUE;
    count_after = count + CW'(push) - CW'(pop);
    state_d = state_q == ISSUE ? HOLD :
              (state_q == IDLE || res_ready) ? (count_after != '0 ? ISSUE : IDLE) : state_q;
    res_data_d = pop ? alu_r : res_data_q;
    err_d = err_q || (in_valid && illegal);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_data_q <= res_data_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    issuing = state_q == ISSUE;
`ifdef ALU_ISSUE_ACC_EN
    a_sel = head_acc ? res_data_q : head_a;
`else
    // acc travels with the entry but has no effect in this build
    a_sel = head_acc ? head_a : head_a;
`endif
    alu_a = issuing ? a_sel : '0;
    alu_b = issuing ? head_b : '0;
    alu_f = issuing ? head_f : '0;
    res_valid = state_q == HOLD;
    res_data = res_data_q;
    err = err_q;
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: transaction-level model plus directed literal checks for alu_issue.
module tb_alu_issue;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  localparam int W = 32;
  logic clk = 0, rst = 1, in_valid = 0, in_acc = 0, res_ready = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic [2:0] in_f = 0;
  logic in_ready, res_valid, err;
  logic [W-1:0] alu_a, alu_b, alu_r, res_data;
  logic [2:0] alu_f;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] got[$];

  alu_issue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_r(alu_r),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    logic [W-1:0] x, y;
    x = W'(a[15:0]);
    y = W'(b[15:0]);
    case (f)
      F_ADD: return a + b;
      F_INC: return a + 1;
      F_SUB: return a - b;
      F_DEC: return a - 1;
      default: return f[2:1] == 2'b10 ? x * y : '0;
    endcase
  endfunction
  assign alu_r = alu(alu_a, alu_b, alu_f);

  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, g, e, $time);
    end
  endtask

  typedef struct {logic [W-1:0] a, b; logic [2:0] f; logic acc;} op_t;
  op_t q[$];
  op_t m_head;
  bit m_issue = 0, m_valid = 0, m_err = 0, m_push = 0;
  logic [W-1:0] m_res = 0;

  function automatic logic [W-1:0] opa(input op_t h);
`ifdef ALU_ISSUE_ACC_EN
    return h.acc ? m_res : h.a;
`else
    return h.a;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_issue = 0;
      m_valid = 0;
      m_err = 0;
      m_res = 0;
    end else begin
      m_push = in_valid && in_f[2:1] != 2'b11 && q.size() < DEPTH;
      if (in_valid && in_f[2:1] == 2'b11) m_err = 1;
      if (m_issue) begin
        m_head = q.pop_front();
        m_res = alu(opa(m_head), m_head.b, m_head.f);
        m_valid = 1;
        m_issue = 0;
        if (m_push) q.push_back('{in_a, in_b, in_f, in_acc});
      end else begin
        if (m_push) q.push_back('{in_a, in_b, in_f, in_acc});
        if (!m_valid || res_ready) begin
          m_valid = 0;
          m_issue = q.size() != 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, in_f[2:1] == 2'b11 || q.size() < DEPTH);
    chk("count", count, q.size());
    chk("err", err, m_err);
    chk("res_valid", res_valid, m_valid);
    if (m_valid) chk("res_data", res_data, m_res);
    chk("alu_a", alu_a, (m_issue && q.size() > 0) ? opa(q[0]) : '0);
    chk("alu_b", alu_b, (m_issue && q.size() > 0) ? q[0].b : '0);
    chk("alu_f", alu_f, (m_issue && q.size() > 0) ? q[0].f : 3'd0);
    if (res_valid && res_ready) got.push_back(res_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f, input logic acc);
    in_valid = 1; in_a = a; in_b = b; in_f = f; in_acc = acc;
    tick();
  endtask
  task automatic idle(input int n);
    in_valid = 0; in_f = 0; in_acc = 0;
    repeat (n) tick();
  endtask

  int base;
  initial begin
    repeat (2) tick();
    rst = 0;
    at_neg();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_a", alu_a, 0);
    // single add: ISSUE next cycle, result the cycle after
    res_ready = 1;
    tick();
    put(5, 3, 3'b000, 0);
    in_valid = 0;
    at_neg();
    chk("add_issue_alu_a", alu_a, 5);
    chk("add_issue_valid", res_valid, 0);
    tick();
    at_neg();
    chk("add_valid", res_valid, 1);
    chk("add_data", res_data, 8);
    tick();
    at_neg();
    chk("add_idle_valid", res_valid, 0);
    tick();
    // back-to-back sub / inc / mul
    base = got.size();
    put(10, 4, 3'b010, 0);
    put(7, 99, 3'b001, 0);
    put(32'h1234, 32'h10, 3'b100, 0);
    idle(8);
    chk("b2b_count", got.size() - base, 3);
    chk("b2b_r0", got[base], 6);
    chk("b2b_r1", got[base + 1], 8);
    chk("b2b_r2", got[base + 2], 32'h12340);
    // illegal op
    chk("ill_err_before", err, 0);
    put(1, 1, 3'b110, 0);
    in_valid = 0;
    at_neg();
    chk("ill_err", err, 1);
    chk("ill_count", count, 0);
    tick();
    // accumulate
    base = got.size();
    put(2, 3, 3'b000, 0);
    put(20, 4, 3'b000, 1);
    idle(8);
    chk("acc_r0", got[base], 5);
`ifdef ALU_ISSUE_ACC_EN
    chk("acc_r1", got[base + 1], 9);
`else
    chk("acc_r1", got[base + 1], 24);
`endif
    chk("acc_err_sticky", err, 1);
    // fill with res_ready low
    res_ready = 0;
    for (int i = 0; i < 7; i++) put(100, 1, 3'b000, 0);
    at_neg();
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", res_valid, 1);
    chk("full_data", res_data, 101);
    res_ready = 1;
    tick();
    res_ready = 0;
    at_neg();
    chk("pulse_count", count, 4);
    chk("pulse_in_ready", in_ready, 0);
    chk("pulse_alu_a", alu_a, 100);
    tick();
    at_neg();
    chk("pop_count", count, 3);
    chk("pop_in_ready", in_ready, 1);
    tick();
    at_neg();
    chk("refill_count", count, 4);
    in_valid = 0;
    // reset while holding a result
    base = got.size();
    rst = 1;
    tick();
    at_neg();
    chk("abort_valid", res_valid, 0);
    chk("abort_count", count, 0);
    chk("abort_err", err, 0);
    chk("abort_in_ready", in_ready, 1);
    rst = 0;
    tick();
    chk("abort_no_result", got.size() - base, 0);
    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom;
      in_b = $urandom;
      in_f = 3'($urandom_range(0, 6));
      in_acc = 1'($urandom_range(0, 1));
      res_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    res_ready = 1;
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
